// File: rtl/reg_bank_mp_if.sv
// Bus interface for reg_bank_mp: write port, read ports, scoreboard set and status.
interface reg_bank_mp_if #(
  parameter int unsigned WL  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic              wr_en;
  logic [AW-1:0]     w_addr;
  logic [WL-1:0]     w_data;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] r_addr;
  logic [NRD*WL-1:0] r_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic [NRD-1:0]    busy;
  logic              ready;

  modport master (
    output wr_en, w_addr, w_data, rd_en, r_addr, sb_set, sb_addr,
    input  r_data, busy, ready
  );

  modport slave (
    input  wr_en, w_addr, w_data, rd_en, r_addr, sb_set, sb_addr,
    output r_data, busy, ready
  );
endinterface

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: one write port, NRD combinational read ports,
// r0 hardwired to zero, post-reset clear engine and RAW pending scoreboard.
// Optional same-cycle write-to-read forwarding under `REG_BANK_BYPASS_EN.
module reg_bank_mp #(
  parameter int unsigned WL  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
) (
  input  logic         clk,
  input  logic         rst,
  reg_bank_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [WL-1:0]  rb [DEPTH];
  logic           ready_c;
  logic           wr_ok_c;
  logic           sb_ok_c;

  assign ready_c = (state_q == IDLE);
  assign wr_ok_c = ready_c && bus.wr_en  && (bus.w_addr  != '0);
  assign sb_ok_c = ready_c && bus.sb_set && (bus.sb_addr != '0);
  assign bus.ready = ready_c;

  // State, clear counter and pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: walk the clear counter, then maintain the scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        // A write retires the producer; a same-cycle set is a newer producer and wins.
        if (wr_ok_c) pend_d[bus.w_addr]  = 1'b0;
        if (sb_ok_c) pend_d[bus.sb_addr] = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
    pend_d[0] = 1'b0;
  end

  // Array storage: clear engine owns the write port until the bank is ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) rb[cnt_q] <= '0;
      else if (wr_ok_c)     rb[bus.w_addr] <= bus.w_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic [WL-1:0] rdata;
    logic          bsy;

    assign ra = bus.r_addr[i*AW +: AW];
`ifdef REG_BANK_BYPASS_EN
    assign hit = wr_ok_c && bus.rd_en[i] && (ra == bus.w_addr);
`else
    assign hit = 1'b0;
`endif

    // Read mux: gated to zero when disabled, r0 or clearing; forwarding overrides.
    always_comb begin
      rdata = '0;
      bsy   = 1'b0;
      if (ready_c && bus.rd_en[i]) begin
        bsy = pend_q[ra];
        if (ra != '0) rdata = rb[ra];
      end
      if (hit) begin
        rdata = bus.w_data;
        bsy   = 1'b0;
      end
    end

    assign bus.r_data[i*WL +: WL] = rdata;
    assign bus.busy[i]            = bsy;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed and randomised checks for reg_bank_mp (both REG_BANK_BYPASS_EN settings).
module tb_reg_bank_mp;

  localparam int unsigned WL    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned DEPTH = 32;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_mp_if #(.WL(WL), .AW(AW), .NRD(NRD)) bus ();
  reg_bank_mp #(.WL(WL), .AW(AW), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [WL-1:0] mdl   [DEPTH];
  bit            mpend [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.rd_en   = '0;
    bus.r_addr  = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    bus.rd_en[p] = en;
    bus.r_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [WL-1:0] rdat(input int p);
    return bus.r_data[p*WL +: WL];
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    set_rd(0, 1'b1, AW'(5));
    set_rd(1, 1'b1, AW'(31));
    repeat (3) tick();
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 2'b00 || bus.r_data !== '0) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b r_data=%h required 0/00/0", bus.ready, bus.busy, bus.r_data);
    end
    rst         = 1'b0;
    bus.wr_en   = 1'b1;
    bus.w_data  = '1;
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(5);
    for (int k = 1; k <= int'(DEPTH); k++) begin
      bus.w_addr = AW'(k);
      tick();
      #1;
      checks++;
      if (bus.ready !== (k == int'(DEPTH))) begin
        failures++;
        $display("FAIL clear_ready edge=%0d ready=%b required %b", k, bus.ready, (k == int'(DEPTH)));
      end
      if (k < int'(DEPTH)) begin
        checks++;
        if (bus.r_data !== '0 || bus.busy !== 2'b00) begin
          failures++;
          $display("FAIL clear_outputs edge=%0d r_data=%h busy=%b required 0/00", k, bus.r_data, bus.busy);
        end
      end
    end
    idle_inputs();
    for (int j = 1; j < int'(DEPTH); j++) begin
      set_rd(0, 1'b1, AW'(j));
      #1;
      checks++;
      if (rdat(0) !== '0 || bus.busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL clear_entry r%0d data=%h busy=%b required 0/0", j, rdat(0), bus.busy[0]);
      end
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    bus.wr_en  = 1'b1;
    bus.w_addr = AW'(7);
    bus.w_data = 32'hDEADBEEF;
    set_rd(0, 1'b1, AW'(7));
    set_rd(1, 1'b1, AW'(7));
    #1;
    checks++;
    if (rdat(1) !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      failures++;
      $display("FAIL basic_same_cycle p1=%h required %h", rdat(1), (BYP ? 32'hDEADBEEF : 32'h0));
    end
    tick();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (rdat(0) !== 32'hDEADBEEF || rdat(1) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_r7 p0=%h p1=%h required deadbeef", rdat(0), rdat(1));
    end
    bus.wr_en  = 1'b1;
    bus.w_addr = AW'(0);
    bus.w_data = 32'h11111111;
    tick();
    bus.wr_en = 1'b0;
    set_rd(0, 1'b1, AW'(0));
    set_rd(1, 1'b1, AW'(0));
    #1;
    checks++;
    if (rdat(0) !== '0 || rdat(1) !== '0) begin
      failures++;
      $display("FAIL basic_r0 p0=%h p1=%h required 0", rdat(0), rdat(1));
    end
    set_rd(0, 1'b0, AW'(7));
    set_rd(1, 1'b1, AW'(7));
    #1;
    checks++;
    if (rdat(0) !== '0 || rdat(1) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_rd_en p0=%h p1=%h required 0/deadbeef", rdat(0), rdat(1));
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(9);
    set_rd(0, 1'b1, AW'(9));
    set_rd(1, 1'b1, AW'(9));
    #1;
    checks++;
    if (bus.busy !== 2'b00) begin
      failures++;
      $display("FAIL sb_before_edge busy=%b required 00", bus.busy);
    end
    tick();
    bus.sb_set = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 2'b11) begin
      failures++;
      $display("FAIL sb_set_r9 busy=%b required 11", bus.busy);
    end
    bus.wr_en  = 1'b1;
    bus.w_addr = AW'(9);
    bus.w_data = 32'h5;
    #1;
    checks++;
    if (bus.busy[0] !== !BYP || rdat(0) !== (BYP ? 32'h5 : 32'h0)) begin
      failures++;
      $display("FAIL sb_write_same_cycle busy=%b data=%h required %b/%h", bus.busy[0], rdat(0), !BYP, (BYP ? 32'h5 : 32'h0));
    end
    tick();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 2'b00 || rdat(0) !== 32'h5) begin
      failures++;
      $display("FAIL sb_write_clears busy=%b data=%h required 00/5", bus.busy, rdat(0));
    end
    bus.wr_en   = 1'b1;
    bus.w_addr  = AW'(9);
    bus.w_data  = 32'h6;
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(9);
    tick();
    idle_inputs();
    set_rd(0, 1'b1, AW'(9));
    #1;
    checks++;
    if (bus.busy[0] !== 1'b1 || rdat(0) !== 32'h6) begin
      failures++;
      $display("FAIL sb_set_wins busy=%b data=%h required 1/6", bus.busy[0], rdat(0));
    end
    bus.wr_en  = 1'b1;
    bus.w_addr = AW'(9);
    bus.w_data = 32'h7;
    tick();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.busy[0] !== 1'b0 || rdat(0) !== 32'h7) begin
      failures++;
      $display("FAIL sb_retire busy=%b data=%h required 0/7", bus.busy[0], rdat(0));
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    bus.wr_en   = 1'b1;
    bus.w_addr  = AW'(3);
    bus.w_data  = 32'hAAAA;
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(3);
    tick();
    idle_inputs();
    set_rd(1, 1'b1, AW'(3));
    #1;
    checks++;
    if (bus.busy[1] !== 1'b1 || rdat(1) !== 32'hAAAA) begin
      failures++;
      $display("FAIL byp_setup busy=%b data=%h required 1/aaaa", bus.busy[1], rdat(1));
    end
    bus.wr_en  = 1'b1;
    bus.w_addr = AW'(3);
    bus.w_data = 32'h1234;
    set_rd(0, 1'b0, AW'(3));
    #1;
    checks++;
    if (rdat(1) !== (BYP ? 32'h1234 : 32'hAAAA) || bus.busy[1] !== !BYP) begin
      failures++;
      $display("FAIL byp_same_cycle data=%h busy=%b required %h/%b", rdat(1), bus.busy[1], (BYP ? 32'h1234 : 32'hAAAA), !BYP);
    end
    checks++;
    if (rdat(0) !== '0 || bus.busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL byp_disabled_port data=%h busy=%b required 0/0", rdat(0), bus.busy[0]);
    end
    tick();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (rdat(1) !== 32'h1234 || bus.busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL byp_next_cycle data=%h busy=%b required 1234/0", rdat(1), bus.busy[1]);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    bus.wr_en   = 1'b1;
    bus.w_addr  = AW'(12);
    bus.w_data  = 32'hCAFE;
    bus.sb_set  = 1'b1;
    bus.sb_addr = AW'(15);
    tick();
    idle_inputs();
    set_rd(0, 1'b1, AW'(12));
    set_rd(1, 1'b1, AW'(15));
    #1;
    checks++;
    if (rdat(0) !== 32'hCAFE || bus.busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL midclr_setup data=%h busy=%b required cafe/1", rdat(0), bus.busy[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      tick();
      checks++;
      if (bus.ready !== (k == int'(DEPTH))) begin
        failures++;
        $display("FAIL midclr_ready edge=%0d ready=%b required %b", k, bus.ready, (k == int'(DEPTH)));
      end
    end
    #1;
    checks++;
    if (rdat(0) !== '0 || bus.busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL midclr_cleared r12=%h busy15=%b required 0/0", rdat(0), bus.busy[1]);
    end
  endtask

  task automatic test_random();
    logic          we, sb;
    logic [AW-1:0] wa, sa, a;
    logic [WL-1:0] wd, ed;
    logic          eb;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DEPTH) tick();
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL rand_ready ready=%b required 1", bus.ready);
    end
    for (int j = 0; j < int'(DEPTH); j++) begin
      mdl[j]   = '0;
      mpend[j] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, 7));
      wd = WL'($urandom);
      sb = 1'($urandom_range(0, 1));
      sa = AW'($urandom_range(0, 7));
      bus.wr_en   = we;
      bus.w_addr  = wa;
      bus.w_data  = wd;
      bus.sb_set  = sb;
      bus.sb_addr = sa;
      bus.rd_en   = NRD'($urandom_range(0, 3));
      for (int p = 0; p < int'(NRD); p++) bus.r_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < int'(NRD); p++) begin
        a  = bus.r_addr[p*AW +: AW];
        ed = (bus.rd_en[p] && a != '0) ? mdl[a] : '0;
        eb = bus.rd_en[p] && mpend[a];
        if (BYP && we && wa != '0 && bus.rd_en[p] && a == wa) begin
          ed = wd;
          eb = 1'b0;
        end
        checks++;
        if (rdat(p) !== ed || bus.busy[p] !== eb) begin
          failures++;
          $display("FAIL rand cyc=%0d port=%0d addr=%0d data=%h busy=%b required %h/%b", c, p, a, rdat(p), bus.busy[p], ed, eb);
        end
      end
      if (we && wa != '0) begin
        mdl[wa]   = wd;
        mpend[wa] = 1'b0;
      end
      if (sb && sa != '0) mpend[sa] = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_scoreboard();
    test_bypass();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-port register bank for the MIPS pipeline decode stage. It has one write port, NRD combinational read ports, and register 0 hardwired to zero. It adds three features:

- a sequential clear engine that zeroes the array one entry per cycle after reset;
- a per-register pending scoreboard for RAW hazard detection;
- an optional same-cycle write-to-read bypass.

## Interface
- WL, 32: register word length in bits
- AW, 5: address width; depth is 2**AW entries
- NRD, 2: number of read ports, 1..4
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe
- w_addr  in  AW  write address
- w_data  in  WL  write data
- rd_en  in  NRD  per-port read enable
- r_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- r_data  out  NRD*WL  read data; port i occupies bits [i*WL +: WL]
- sb_set  in  1  mark the destination register of an issued instruction as pending
- sb_addr  in  AW  register to mark pending
- busy  out  NRD  read port i targets a pending register
- ready  out  1  clear engine idle; array valid

## Operation
- FSM states: CLEAR, IDLE.
- rst at an edge: state←CLEAR, clear counter←0, every pending bit←0.
- CLEAR, rst low, each edge: RB[cnt]←0, cnt←cnt+1. On the edge where cnt==2**AW-1, state←IDLE.
- rst asserted mid-clear restarts the clear from index 0.
- While in CLEAR:
  - ready=0;
  - wr_en and sb_set are ignored;
  - all r_data=0 and all busy=0.
- IDLE writes: wr_en && w_addr!=0 → RB[w_addr]←w_data at the edge. Writes to address 0 are dropped.
- IDLE reads, port i, combinational:
  - rd_en[i]=0 → r_data port i = 0 (never X);
  - r_addr[i]==0 → 0;
  - otherwise RB[r_addr[i]].
- Scoreboard, IDLE only:
  - sb_set && sb_addr!=0 sets pending[sb_addr].
  - wr_en && w_addr!=0 clears pending[w_addr].
  - Set and write to the same address in the same cycle: set wins, pending stays 1 (a newer producer has issued).
  - pending[0] is constant 0.
- busy[i] = rd_en[i] & pending[r_addr[i]] & ready.
- Ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: ready=0, busy=0, r_data=0, pending all 0, state CLEAR.
- ready rises exactly 2**AW edges after the first edge with rst low following reset: 32 edges for AW=5.
- Read latency is 0 cycles (combinational from r_addr, rd_en, array and pending).
- Write-to-read latency is 1 edge without bypass: data written at edge t is visible after edge t.
- Pending bits change only at edges. busy reflects sb_set issued at edge t from after edge t.

## Configuration
- Macro: REG_BANK_BYPASS_EN.
- Defined:
  - If wr_en && w_addr!=0 && rd_en[i] && r_addr[i]==w_addr in IDLE, r_data port i = w_data in the same cycle.
  - busy[i] is forced 0 in that cycle, because the data is being forwarded.
- Undefined:
  - r_data shows the old array contents until the edge.
  - busy[i] stays asserted until the edge that clears pending.

## Test plan
- Reset and clear, AW=5: hold rst 3 cycles, release.
  - ready must be 0 for 31 edges and 1 after the 32nd.
  - All r_data are 0 throughout.
  - Write attempts during clear leave the entries at 0 afterwards.
- Basic write/read, NRD=2:
  - Write 0xDEADBEEF to r7, then read r7 on both ports → 0xDEADBEEF on both, next cycle.
  - Write to r0, then read r0 → 0.
  - rd_en=0 → 0.
- Scoreboard:
  - sb_set r9, then read r9 → busy=1.
  - Write r9=0x5 → busy=0 after the edge and r_data=0x5.
  - Simultaneous sb_set r9 and write r9 → busy remains 1.
- Bypass, with the macro defined:
  - In one cycle, write r3=0x1234 and read r3 on port 1 → r_data port 1 = 0x1234 and busy[1]=0 in that same cycle.
  - Without the macro: old value this cycle, 0x1234 next cycle.
- Reset mid-clear: assert rst at clear index 10, release.
  - ready must rise a full 32 edges after release, not 22.
  - Previously written data is 0.
- Random mixed traffic, both macro settings, 10k cycles: compare every port against a reference model of array plus pending bits plus bypass rule. Zero mismatches.
